stream_conv_layer: RTL

- Streaming, clocked successor to the combinational per-channel convolution stage.
- Accepts one input pixel per beat in raster order, with all input channels in that beat. Holds K-1 rows in line buffers.
- Emits one output-channel pixel per valid KxK window, with requantise, saturate and optional ReLU.
- The network instantiates one per output channel inside the existing generate loop; relu_layer and pool_layer follow it unchanged.

---
 rtl/stream_conv_layer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stream_conv_layer.sv
// stream_conv_layer
// Streaming KxK valid convolution for one output channel. Input pixels arrive
// one per beat in raster order, with every input channel packed into a beat.
// K-1 previous rows live in column-organised line buffers. A sliding window
// holds the K-1 most recent columns, and the newest column is formed
// combinationally from the line buffers plus the incoming pixel.
// The result is requantised with an arithmetic shift, saturated, and
// optionally passed through ReLU.
// Kernel packing: weight (row r, col c, channel ch) sits at bit offset
// ((r*K + c)*C + ch)*PX_SIZE. Row 0 and col 0 are the top-left (oldest) tap.
// The whole pipeline stalls together: in_ready is low only while the output
// register is full and downstream is not taking it.

module stream_conv_layer #(
    parameter int INPUT_SIZE     = 32,
    parameter int INPUT_CHANNELS = 1,
    parameter int KERNEL_SIZE    = 3,
    parameter int PX_SIZE        = 8,
    parameter int FRAC_BITS      = 0,
    parameter int RELU_EN        = 1
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [INPUT_CHANNELS*PX_SIZE-1:0]                         in_px,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS*PX_SIZE-1:0] kernel,
    input  logic [PX_SIZE-1:0]                                        bias,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [PX_SIZE-1:0]                                        out_px,
    output logic                                                      out_last
);

    localparam int K      = KERNEL_SIZE;
    localparam int C      = INPUT_CHANNELS;
    localparam int PX     = PX_SIZE;
    localparam int CW     = C * PX;
    localparam int PROD_W = 2 * PX;
    localparam int ACC_W  = 2 * PX + $clog2(K * K * C + 1);
    localparam int CNT_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

    localparam logic [CNT_W-1:0]        LAST_POS  = CNT_W'(INPUT_SIZE - 1);
    localparam logic [CNT_W-1:0]        FIRST_WIN = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (PX - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(2 ** (PX - 1)));

    // Position of the next pixel to be accepted
    logic [CNT_W-1:0] row_r;
    logic [CNT_W-1:0] col_r;

    // line_buf_r[0] holds the oldest stored row, line_buf_r[K-2] the newest
    logic [CW-1:0] line_buf_r [K-1][INPUT_SIZE];

    // K-1 most recent window columns; column 0 is the oldest
    logic [CW-1:0] win_r      [K][K-1];
    // Full KxK window including the column arriving this beat
    logic [CW-1:0] win_next_s [K][K];

    logic accept_s;
    logic win_valid_s;
    logic frame_end_s;

    logic [PROD_W-1:0]       px_ext_s;
    logic [PROD_W-1:0]       wt_ext_s;
    logic [PROD_W-1:0]       prod_s;
    logic [ACC_W-1:0]        acc_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic [PX-1:0]           sat_s;
    logic [PX-1:0]           result_s;

    // Handshake and position decode for the beat presented this cycle
    always_comb begin
        in_ready    = rst || !out_valid || out_ready;
        accept_s    = in_valid && in_ready && !rst;
        win_valid_s = (row_r >= FIRST_WIN) && (col_r >= FIRST_WIN);
        frame_end_s = (row_r == LAST_POS) && (col_r == LAST_POS);
    end

    // Raster position counters, advanced once per accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r <= '0;
            col_r <= '0;
        end else if (accept_s) begin
            if (col_r == LAST_POS) begin
                col_r <= '0;
                if (row_r == LAST_POS) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + CNT_ONE;
                end
            end else begin
                col_r <= col_r + CNT_ONE;
            end
        end
    end

    // Column store: push the current column up one row and insert the new pixel at the bottom
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < K - 2; i++) begin
                line_buf_r[i][col_r] <= line_buf_r[i + 1][col_r];
            end
            line_buf_r[K - 2][col_r] <= in_px;
        end
    end

    // Assemble the full window: stored columns plus the newest column on the right
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_next_s[r][j] = win_r[r][j];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_next_s[r][K - 1] = line_buf_r[r][col_r];
        end
        win_next_s[K - 1][K - 1] = in_px;
    end

    // Slide the window left by one column on every accepted beat
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < K; r++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_r[r][j] <= win_next_s[r][j + 1];
                end
            end
        end
    end

    // Multiply-accumulate over the window, then requantise, saturate and apply ReLU
    always_comb begin
        acc_s    = {{(ACC_W - PX){bias[PX - 1]}}, bias};
        px_ext_s = '0;
        wt_ext_s = '0;
        prod_s   = '0;
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K; j++) begin
                for (int ch = 0; ch < C; ch++) begin
                    px_ext_s = {{PX{win_next_s[r][j][ch * PX + PX - 1]}},
                                win_next_s[r][j][ch * PX +: PX]};
                    wt_ext_s = {{PX{kernel[((r * K + j) * C + ch) * PX + PX - 1]}},
                                kernel[((r * K + j) * C + ch) * PX +: PX]};
                    prod_s   = px_ext_s * wt_ext_s;
                    acc_s    = acc_s + {{(ACC_W - PROD_W){prod_s[PROD_W - 1]}}, prod_s};
                end
            end
        end
        shifted_s = $signed(acc_s) >>> FRAC_BITS;
        if (shifted_s > SAT_MAX) begin
            sat_s = SAT_MAX[PX - 1:0];
        end else if (shifted_s < SAT_MIN) begin
            sat_s = SAT_MIN[PX - 1:0];
        end else begin
            sat_s = shifted_s[PX - 1:0];
        end
        if ((RELU_EN != 0) && sat_s[PX - 1]) begin
            result_s = '0;
        end else begin
            result_s = sat_s;
        end
    end

    // Output register: load on a completed window, clear once the held beat is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_px    <= '0;
            out_last  <= 1'b0;
        end else if (accept_s && win_valid_s) begin
            out_valid <= 1'b1;
            out_px    <= result_s;
            out_last  <= frame_end_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
